// File: rtl/cnn_argmax_collector.sv
// cnn_argmax_collector
//   Collects one burst of NUM_CLASS fp32 scores from the CNN stage and
//   reports the index and bits of the largest score in a one-cycle pulse.
//   A burst cut short (in_valid low before the last word) raises a
//   one-cycle err pulse and the partial burst is dropped.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : word strobe from the CNN
//   in_data    : fp32 score
//   out_valid  : one-cycle result strobe
//   out_class  : arrival index of the maximum score (0 when out_valid = 0)
//   out_max    : fp32 bits of the maximum, -0.0 reported as +0.0
//   err        : one-cycle pulse on a truncated burst
//   out_second : (ARGMAX_RUNNER_UP_EN only) index of the second-largest score
//
// Optional feature macro: ARGMAX_RUNNER_UP_EN
module cnn_argmax_collector #(
  parameter int NUM_CLASS = 4,
  parameter int IDX_W     = $clog2(NUM_CLASS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_class,
  output logic [31:0]      out_max,
  output logic             err
`ifdef ARGMAX_RUNNER_UP_EN
  ,
  output logic [IDX_W-1:0] out_second
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_REPORT  = 2'd2
  } state_t;

  // Fold -0.0 onto +0.0 so both zeros compare equal and report as +0.0.
  function automatic logic [31:0] fp_norm(input logic [31:0] bits);
    return (bits == 32'h8000_0000) ? 32'h0000_0000 : bits;
  endfunction

  // Monotonic unsigned key: unsigned order of keys equals float order.
  function automatic logic [31:0] fp_key(input logic [31:0] bits);
    logic [31:0] nb;
    nb = fp_norm(bits);
    return nb[31] ? ~nb : (nb ^ 32'h8000_0000);
  endfunction

  state_t           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [31:0]      best_key_q;
  logic [31:0]      best_bits_q;
  logic [IDX_W-1:0] best_idx_q;
  logic             out_valid_q;
  logic [IDX_W-1:0] out_class_q;
  logic [31:0]      out_max_q;
  logic             err_q;

  logic [31:0]      key_s;
  logic [31:0]      word_s;
  logic             gt_best_s;
  logic [31:0]      best_key_d;
  logic [31:0]      best_bits_d;
  logic [IDX_W-1:0] best_idx_d;

`ifdef ARGMAX_RUNNER_UP_EN
  logic [31:0]      second_key_q;
  logic [IDX_W-1:0] second_idx_q;
  logic             second_vld_q;
  logic [IDX_W-1:0] out_second_q;
  logic             gt_second_s;
  logic [31:0]      second_key_d;
  logic [IDX_W-1:0] second_idx_d;
`endif

  // Running-best update for the word currently on in_data (COLLECT only).
  always_comb begin
    key_s       = fp_key(in_data);
    word_s      = fp_norm(in_data);
    gt_best_s   = (key_s > best_key_q);
    best_key_d  = gt_best_s ? key_s  : best_key_q;
    best_bits_d = gt_best_s ? word_s : best_bits_q;
    best_idx_d  = gt_best_s ? cnt_q  : best_idx_q;
`ifdef ARGMAX_RUNNER_UP_EN
    // A new best demotes the old best; otherwise the first non-best word
    // (second not yet valid) or a strictly greater word takes second place.
    gt_second_s  = (!second_vld_q) || (key_s > second_key_q);
    second_key_d = gt_best_s ? best_key_q : (gt_second_s ? key_s : second_key_q);
    second_idx_d = gt_best_s ? best_idx_q : (gt_second_s ? cnt_q : second_idx_q);
`endif
  end

  // Burst FSM with registered result/err outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      best_key_q   <= 32'h0000_0000;
      best_bits_q  <= 32'h0000_0000;
      best_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_max_q    <= 32'h0000_0000;
      err_q        <= 1'b0;
`ifdef ARGMAX_RUNNER_UP_EN
      second_key_q <= 32'h0000_0000;
      second_idx_q <= '0;
      second_vld_q <= 1'b0;
      out_second_q <= '0;
`endif
    end else begin
      // Pulses and gated outputs default low every cycle.
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_max_q   <= 32'h0000_0000;
      err_q       <= 1'b0;
`ifdef ARGMAX_RUNNER_UP_EN
      out_second_q <= '0;
`endif
      case (state_q)
        // A word during REPORT starts the next burst exactly like IDLE.
        S_IDLE, S_REPORT: begin
          if (in_valid) begin
            best_key_q  <= key_s;
            best_bits_q <= word_s;
            best_idx_q  <= '0;
            cnt_q       <= IDX_W'(1);
            state_q     <= S_COLLECT;
`ifdef ARGMAX_RUNNER_UP_EN
            second_vld_q <= 1'b0;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_COLLECT: begin
          if (!in_valid) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            best_key_q  <= best_key_d;
            best_bits_q <= best_bits_d;
            best_idx_q  <= best_idx_d;
`ifdef ARGMAX_RUNNER_UP_EN
            second_key_q <= second_key_d;
            second_idx_q <= second_idx_d;
            second_vld_q <= 1'b1;
`endif
            if (cnt_q == LAST_IDX) begin
              out_valid_q <= 1'b1;
              out_class_q <= best_idx_d;
              out_max_q   <= best_bits_d;
`ifdef ARGMAX_RUNNER_UP_EN
              out_second_q <= second_idx_d;
`endif
              cnt_q   <= '0;
              state_q <= S_REPORT;
            end else begin
              cnt_q   <= cnt_q + IDX_W'(1);
              state_q <= S_COLLECT;
            end
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_max   = out_max_q;
  assign err       = err_q;
`ifdef ARGMAX_RUNNER_UP_EN
  assign out_second = out_second_q;
`endif

endmodule
